ascii_msg_sequencer: RTL
========================

// Module: ascii_msg_sequencer
// PURPOSE
//   Message controller for the one-digit ASCII 7-segment driver. Buffers up to DEPTH
//   ASCII characters loaded over a valid/ready port. On start, plays them back one at a
//   time on ASCII_out for a fixed dwell, with a blank gap between characters.
//   Sits between user logic and ASCII_to_1_Digit_CA. Replaces the free-running Counter128 source.
// PARAMETERS
//   TICK_DIV   25_000_000  clock cycles per display tick (2 Hz at 50 MHz); >=1
//   DEPTH      16          message buffer size in characters; power of 2, >=2
//   SHOW_TICKS 2           ticks each character is shown; >=1
//   GAP_TICKS  1           ticks of blank (space) after each character; 0 = no gap
// PORTS
//   clk50MHz   in   1  main clock, 50 MHz
//   rst_n      in   1  asynchronous active-low reset
//   wr_valid   in   1  write request: append wr_data to buffer
//   wr_data    in   7  ASCII character to append
//   wr_ready   out  1  write accepted when wr_valid & wr_ready at a rising edge
//   clear      in   1  empty buffer (length := 0); honoured only in IDLE
//   start      in   1  begin playback; honoured only in IDLE with length > 0
//   stop       in   1  abort playback immediately
//   busy       out  1  high while not IDLE
//   done       out  1  one-cycle pulse when playback completes normally
//   ASCII_out  out  7  character to decoder ASCII_in
//   dp_out     out  1  decoder dp_in; high while the last buffer character is shown
// BEHAVIOUR
//   - Reset (async, rst_n=0): state IDLE, length 0, index 0, dwell counter 0.
//     Outputs: ASCII_out=7'h20, dp_out=0, busy=0, done=0. wr_ready=1 once reset is released.
//   - wr_ready = (state==IDLE) & (length<DEPTH), combinational from state and length.
//     An accepted write stores to buf[length], then length+1. A write while full or busy is ignored.
//   - States: IDLE, SHOW, GAP.
//     IDLE->SHOW on start & length>0 & !clear & !accepted-write-this-cycle.
//     The index and dwell counter are zeroed on that transition.
//   - Timing: start sampled at edge N. From edge N onward, ASCII_out=buf[0] and busy=1.
//     The first character is visible in the cycle after edge N. All outputs are registered.
//   - SHOW lasts exactly SHOW_TICKS*TICK_DIV cycles, then goes to GAP.
//     If GAP_TICKS=0, it goes directly to the next SHOW instead.
//   - GAP lasts exactly GAP_TICKS*TICK_DIV cycles with ASCII_out=7'h20 and dp_out=0.
//     Then index+1 and SHOW.
//   - After the last character (index==length-1) finishes its SHOW+GAP:
//     -> IDLE, done=1 for one cycle, ASCII_out=7'h20.
//   - The dwell counter restarts from 0 on every state entry.
//     No carry-over, no free-running divider phase.
//   - stop in SHOW/GAP: next edge -> IDLE, ASCII_out=7'h20, dp_out=0, no done pulse.
//     Buffer contents and length are kept. stop has priority over every dwell transition.
//   - Simultaneous inputs in IDLE: clear > write > start.
//     clear+wr_valid gives length 0 (write dropped). start with an accepted write is ignored.
//   - start/clear while busy: ignored. Buffer contents are unchanged by playback.
// CONFIGURATION
//   MSG_LOOP_EN defined: after the last character's gap, index wraps to 0 and SHOW
//     continues indefinitely. done never pulses; only stop or reset ends playback.
//   MSG_LOOP_EN undefined: single pass, then IDLE with a done pulse (as above).
// STRUCTURE
//   ascii_seq_defs.vh: state encodings (IDLE/SHOW/GAP), ASCII_SPACE=7'h20.
//   Sub-module dwell_timer: cycle counter with load/restart.
//     Asserts expire when count == SHOW_TICKS*TICK_DIV-1 or GAP_TICKS*TICK_DIV-1.
//     The target is selected by state. Counter width is $clog2 of the larger product.
//   Buffer: DEPTH x 7 register array, write-only from the port, read by index.
// TESTING (bench uses TICK_DIV=4, DEPTH=4, SHOW_TICKS=2, GAP_TICKS=1)
//   1. Reset, write "H","I" (7'h48,7'h49), start.
//      Expected ASCII_out sequence: 48 x8 cycles, 20 x4, 49 x8 (dp_out=1), 20 x4.
//      Then done pulses for 1 cycle, busy=0.
//   2. Write 4 chars; 5th wr_valid -> wr_ready=0 and length stays 4.
//      start then shows exactly 4 chars.
//   3. start with length 0 -> stays IDLE, busy=0, no done.
//      clear+wr_valid in the same cycle -> length 0.
//   4. stop at cycle 5 of the second SHOW -> IDLE next edge, ASCII_out=20, no done.
//      Restart replays from buf[0].
//   5. rst_n low mid-GAP -> immediate IDLE with reset output values, length 0.
//   6. MSG_LOOP_EN, 2 chars: after 24 cycles ASCII_out=buf[0] again and no done.
//      stop ends playback.

Source files
------------

// File: rtl/ascii_msg_sequencer_pkg.sv
// ascii_msg_sequencer_pkg: shared state encoding, blank character and counter-width helper.
package ascii_msg_sequencer_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_t;
   localparam logic [6:0] ASCII_SPACE = 7'h20;
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/ascii_msg_sequencer_if.sv
// ascii_msg_sequencer_if: write port, playback controls and decoder-facing outputs.
interface ascii_msg_sequencer_if;
   logic       wr_valid;
   logic [6:0] wr_data;
   logic       wr_ready;
   logic       clear;
   logic       start;
   logic       stop;
   logic       busy;
   logic       done;
   logic [6:0] ASCII_out;
   logic       dp_out;
   modport master (output wr_valid, wr_data, clear, start, stop,
                   input wr_ready, busy, done, ASCII_out, dp_out);
   modport slave  (input wr_valid, wr_data, clear, start, stop,
                   output wr_ready, busy, done, ASCII_out, dp_out);
endinterface

// File: rtl/ascii_msg_sequencer_dwell_timer.sv
// ascii_msg_sequencer_dwell_timer: cycle counter restarted on state entry; expires on the
// last cycle of the show or gap dwell selected by i_gap.
module ascii_msg_sequencer_dwell_timer
   import ascii_msg_sequencer_pkg::*;
#(
   parameter int SHOW_CYC = 8,
   parameter int GAP_CYC  = 4
) (
   input  logic clk50MHz,
   input  logic rst_n,
   input  logic i_restart,
   input  logic i_gap,
   output logic o_expire
);
   localparam int GAP_T = (GAP_CYC > 0) ? GAP_CYC : 1;
   localparam int W = cnt_w((SHOW_CYC > GAP_T) ? SHOW_CYC : GAP_T);
   logic [W-1:0] r_cnt;
   logic [W-1:0] w_tgt;
   assign w_tgt = i_gap ? W'(GAP_T - 1) : W'(SHOW_CYC - 1);
   assign o_expire = (r_cnt == w_tgt);
   always_ff @(posedge clk50MHz or negedge rst_n)
      if (!rst_n) r_cnt <= '0;
      else        r_cnt <= i_restart ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/ascii_msg_sequencer.sv
// ascii_msg_sequencer: buffers ASCII characters and plays them back with dwell and blank gap.
// Define MSG_LOOP_EN to replay the message endlessly instead of a single pass with done.
module ascii_msg_sequencer
   import ascii_msg_sequencer_pkg::*;
#(
   parameter int TICK_DIV   = 25_000_000,
   parameter int DEPTH      = 16,
   parameter int SHOW_TICKS = 2,
   parameter int GAP_TICKS  = 1
) (
   input  logic                  clk50MHz,
   input  logic                  rst_n,
   ascii_msg_sequencer_if.slave  bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int LW = IW + 1;
   state_t         r_state, w_state_n;
   logic [IW-1:0]  r_idx, w_idx_n;
   logic [LW-1:0]  r_len, w_len_n;
   logic [6:0]     r_buf [DEPTH];
   logic [6:0]     r_ascii;
   logic           r_dp, r_busy, r_done, w_done_n;
   logic           w_acc, w_go, w_exp, w_last, w_restart;
   assign bus.wr_ready  = (r_state == ST_IDLE) && (r_len < LW'(DEPTH));
   assign bus.ASCII_out = r_ascii;
   assign bus.dp_out    = r_dp;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign w_acc     = bus.wr_valid & bus.wr_ready;
   assign w_go      = bus.start & (r_len != '0) & ~bus.clear & ~w_acc;
   assign w_last    = ({1'b0, r_idx} == r_len - 1'b1);
   assign w_restart = (w_state_n != r_state) | w_exp | (r_state == ST_IDLE);
   assign w_len_n   = (r_state == ST_IDLE && bus.clear) ? '0 : w_acc ? r_len + 1'b1 : r_len;
   ascii_msg_sequencer_dwell_timer #(
      .SHOW_CYC (SHOW_TICKS * TICK_DIV),
      .GAP_CYC  (GAP_TICKS * TICK_DIV)
   ) u_timer (
      .clk50MHz (clk50MHz),
      .rst_n    (rst_n),
      .i_restart(w_restart),
      .i_gap    (r_state == ST_GAP),
      .o_expire (w_exp)
   );
   // stop outranks any dwell expiry; with no gap a show expiry advances straight to the next show
   always_comb begin
      w_state_n = r_state;
      w_idx_n   = r_idx;
      w_done_n  = 1'b0;
      if (r_state == ST_IDLE) begin
         w_state_n = w_go ? ST_SHOW : ST_IDLE;
         w_idx_n   = w_go ? '0 : r_idx;
      end else if (bus.stop) begin
         w_state_n = ST_IDLE;
      end else if (w_exp && r_state == ST_SHOW && GAP_TICKS > 0) begin
         w_state_n = ST_GAP;
      end else if (w_exp) begin
`ifdef MSG_LOOP_EN
         w_state_n = ST_SHOW;
         w_idx_n   = w_last ? '0 : r_idx + 1'b1;
`else
         w_state_n = w_last ? ST_IDLE : ST_SHOW;
         w_idx_n   = w_last ? r_idx : r_idx + 1'b1;
         w_done_n  = w_last;
`endif
      end
   end
   always_ff @(posedge clk50MHz or negedge rst_n)
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_len   <= '0;
         r_ascii <= ASCII_SPACE;
         r_dp    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_idx   <= w_idx_n;
         r_len   <= w_len_n;
         r_ascii <= (w_state_n == ST_SHOW) ? r_buf[w_idx_n] : ASCII_SPACE;
         r_dp    <= (w_state_n == ST_SHOW) && ({1'b0, w_idx_n} == r_len - 1'b1);
         r_busy  <= (w_state_n != ST_IDLE);
         r_done  <= w_done_n;
      end
   always_ff @(posedge clk50MHz)
      if (w_acc && !bus.clear) r_buf[r_len[IW-1:0]] <= bus.wr_data;
endmodule
